// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC measurement controller: FSM state encoding,
// LED bar size and the reference/threshold defaults also used by the unit top.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_UPDATE   = 3'd4
  } adc_state_t;

  localparam int LED_COUNT   = 5;
  localparam int VREF_MV_DEF = 3300;
  localparam int TH_HI_DEF   = 200;
  localparam int TH_LO_DEF   = 100;

endpackage

// File: rtl/adc_serial_rx.sv
// Serial ADC receiver: generates adclk (CLK_DIV clk cycles per half period,
// low half first) and shifts ADC_BITS bits in MSB-first. A start pulse begins a
// burst; done pulses in the last clk cycle of the burst while data is complete.
module adc_serial_rx #(
  parameter int ADC_BITS = 8,
  parameter int CLK_DIV  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ad_in,
  output logic                adclk,
  output logic                done,
  output logic [ADC_BITS-1:0] data
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (ADC_BITS > 1) ? $clog2(ADC_BITS) : 1;

  logic                busy;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [ADC_BITS-1:0] shreg;
  logic                half_end;

  assign half_end = busy && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done     = half_end && adclk && (bit_cnt == BIT_W'(ADC_BITS - 1));
  assign data     = shreg;

  // Divider and bit sequencing; a reset mid-burst drops adclk immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      adclk   <= 1'b0;
    end else if (start) begin
      busy    <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      adclk   <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      if (!adclk) begin
        adclk <= 1'b1;
      end else begin
        adclk <= 1'b0;
        if (bit_cnt == BIT_W'(ADC_BITS - 1)) begin
          busy <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end else if (busy) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Capture ad_in on the clk edge where adclk rises; data path is not reset.
  always_ff @(posedge clk) begin
    if (half_end && !adclk) begin
      shreg <= {shreg[ADC_BITS-2:0], ad_in};
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Periodic serial-ADC conversion controller: period counter with one-deep
// pending request, frame FSM (cs_n setup / shift / hold / update), millivolt
// scaling, K_1 relay hysteresis and a thermometer LED bar.
// Optional feature macro: ADC_AVG_EN (4-sample moving average of raw codes).
module adc_sample_sequencer
  import adc_ctrl_pkg::*;
#(
  parameter int ADC_BITS      = 8,
  parameter int CLK_DIV       = 16,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int VREF_MV       = VREF_MV_DEF,
  parameter int TH_HI         = TH_HI_DEF,
  parameter int TH_LO         = TH_LO_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ad_in,
  output logic                 adclk,
  output logic                 cs_n,
  output logic [ADC_BITS-1:0]  sample,
  output logic                 sample_valid,
  output logic [15:0]          volt,
  output logic                 K_1,
  output logic [LED_COUNT-1:0] led
);

  localparam int PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int PH_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PROD_W = ADC_BITS + 32;

  function automatic logic [15:0] scale_mv(input logic [ADC_BITS-1:0] c);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'($unsigned(VREF_MV));
    return prod[ADC_BITS +: 16];
  endfunction

  function automatic logic hyst(input logic [ADC_BITS-1:0] c, input logic cur);
    if (c >= ADC_BITS'(TH_HI))      return 1'b1;
    else if (c <= ADC_BITS'(TH_LO)) return 1'b0;
    else                            return cur;
  endfunction

  function automatic logic [LED_COUNT-1:0] led_bar(input logic [ADC_BITS-1:0] c);
    logic [2:0]           seg;
    logic [LED_COUNT-1:0] b;
    seg = c[ADC_BITS-1 -: 3];
    for (int i = 0; i < LED_COUNT; i++) b[i] = (int'(seg) >= i + 1);
    return b;
  endfunction

  adc_state_t          state, state_nxt;
  logic [PER_W-1:0]    per_cnt;
  logic [PH_W-1:0]     ph_cnt;
  logic                tick, pending, rx_start, rx_done, load;
  logic [ADC_BITS-1:0] rx_data, code_p0;

  assign tick = (per_cnt == PER_W'(SAMPLE_PERIOD - 1));
  assign load = (state == ST_CS_HOLD) && (state_nxt == ST_UPDATE);

  adc_serial_rx #(
    .ADC_BITS (ADC_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_rx (
    .clk   (clk),
    .rst   (rst),
    .start (rx_start),
    .ad_in (ad_in),
    .adclk (adclk),
    .done  (rx_done),
    .data  (rx_data)
  );

  // Free-running period counter.
  always_ff @(posedge clk) begin
    if (rst)       per_cnt <= '0;
    else if (tick) per_cnt <= '0;
    else           per_cnt <= per_cnt + 1'b1;
  end

  // State, phase counter, pending request and chip select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ph_cnt  <= '0;
      pending <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      state   <= state_nxt;
      ph_cnt  <= (state_nxt != state) ? '0 : ph_cnt + 1'b1;
      if (state == ST_IDLE && state_nxt == ST_CS_SETUP) pending <= 1'b0;
      else if (tick && state != ST_IDLE)                pending <= 1'b1;
      cs_n    <= !(state_nxt == ST_CS_SETUP || state_nxt == ST_SHIFT);
    end
  end

  // Frame sequencing; the receiver is started on the last setup cycle.
  always_comb begin
    state_nxt = state;
    rx_start  = 1'b0;
    case (state)
      ST_IDLE:     if (tick || pending) state_nxt = ST_CS_SETUP;
      ST_CS_SETUP: if (ph_cnt == PH_W'(CLK_DIV - 1)) begin
                     rx_start  = 1'b1;
                     state_nxt = ST_SHIFT;
                   end
      ST_SHIFT:    if (rx_done) state_nxt = ST_CS_HOLD;
      ST_CS_HOLD:  if (ph_cnt == PH_W'(CLK_DIV - 1)) state_nxt = ST_UPDATE;
      ST_UPDATE:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

`ifdef ADC_AVG_EN
  logic [ADC_BITS-1:0] hist_p0 [3];
  logic [ADC_BITS+1:0] sum_p0;

  assign sum_p0  = (ADC_BITS+2)'(rx_data) + (ADC_BITS+2)'(hist_p0[0]) +
                   (ADC_BITS+2)'(hist_p0[1]) + (ADC_BITS+2)'(hist_p0[2]);
  assign code_p0 = sum_p0[ADC_BITS+1:2];

  // History of the three previous raw codes, advanced once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) hist_p0[i] <= '0;
    end else if (load) begin
      hist_p0[0] <= rx_data;
      hist_p0[1] <= hist_p0[0];
      hist_p0[2] <= hist_p0[1];
    end
  end
`else
  assign code_p0 = rx_data;
`endif

  // Output registers, all updated together with the sample_valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_valid <= 1'b0;
      sample       <= '0;
      volt         <= '0;
      K_1          <= 1'b0;
      led          <= '0;
    end else begin
      sample_valid <= load;
      if (load) begin
        sample <= code_p0;
        volt   <= scale_mv(code_p0);
        K_1    <= hyst(code_p0, K_1);
        led    <= led_bar(code_p0);
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer with a serial ADC model and a
// behavioural reference for code, millivolts, relay hysteresis and LED bar.
module tb_adc_sample_sequencer;

  localparam int ADC_BITS      = 8;
  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 100;
  localparam int VREF_MV       = 3300;
  localparam int TH_HI         = 200;
  localparam int TH_LO         = 100;
  localparam int FRAME_LAT     = 2*CLK_DIV + 2*CLK_DIV*ADC_BITS;

  logic                clk = 1'b0;
  logic                rst;
  logic                ad_in;
  logic                adclk, cs_n, sample_valid, K_1;
  logic [ADC_BITS-1:0] sample;
  logic [15:0]         volt;
  logic [4:0]          led;

  adc_sample_sequencer #(
    .ADC_BITS(ADC_BITS), .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .VREF_MV(VREF_MV), .TH_HI(TH_HI), .TH_LO(TH_LO)
  ) dut (
    .clk(clk), .rst(rst), .ad_in(ad_in), .adclk(adclk), .cs_n(cs_n),
    .sample(sample), .sample_valid(sample_valid), .volt(volt), .K_1(K_1), .led(led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: presents adc_word MSB-first, advancing after each adclk rise.
  logic [ADC_BITS-1:0] adc_word;
  logic                prev_ck = 1'b0;
  int                  nbit = 0;
  always @(negedge clk) begin
    prev_ck <= adclk;
    if (cs_n)                   nbit <= 0;
    else if (adclk && !prev_ck) nbit <= nbit + 1;
  end
  always_comb begin
    ad_in = 1'b0;
    if (!cs_n && nbit < ADC_BITS) ad_in = adc_word[ADC_BITS-1-nbit];
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state.
  int hist_q[$];
  int k1_m;
  int last_fall = -1;

  task automatic model_reset();
    hist_q.delete();
    k1_m = 0;
    last_fall = -1;
  endtask

  task automatic model_expect(input int raw, output int code, output int mv,
                              output int k1, output int ledv);
    int seg;
`ifdef ADC_AVG_EN
    int s;
    hist_q.push_front(raw);
    if (hist_q.size() > 4) void'(hist_q.pop_back());
    s = 0;
    foreach (hist_q[i]) s += hist_q[i];
    code = s / 4;
`else
    code = raw;
`endif
    mv = int'((longint'(code) * VREF_MV) / (longint'(1) << ADC_BITS)) % 65536;
    if (code >= TH_HI)      k1_m = 1;
    else if (code <= TH_LO) k1_m = 0;
    k1 = k1_m;
    seg = code / (1 << (ADC_BITS - 3));
    if (seg > 5) seg = 5;
    ledv = (1 << seg) - 1;
  endtask

  task automatic do_frame(input logic [ADC_BITS-1:0] raw);
    int  n, rises, code, mv, k1, ledv;
    bit  got, stray, ck_bad;
    logic pck;
    adc_word = raw;
    got = 0; stray = 0;
    for (n = 0; n < 2*SAMPLE_PERIOD; n++) begin
      @(negedge clk);
      if (sample_valid) stray = 1;
      if (!cs_n) begin got = 1; break; end
    end
    chk("cs_fall_seen", got, 1);
    if (!got) return;
    chk("no_stray_strobe", stray, 0);
    if (last_fall >= 0) chk("period", cyc - last_fall, SAMPLE_PERIOD);
    last_fall = cyc;
    rises = 0; ck_bad = 0; got = 0; pck = adclk;
    for (n = 1; n <= FRAME_LAT + 10; n++) begin
      @(negedge clk);
      if (cs_n && adclk) ck_bad = 1;
      if (!cs_n && adclk && !pck) rises++;
      pck = adclk;
      if (sample_valid) begin got = 1; break; end
    end
    chk("strobe_seen", got, 1);
    if (!got) return;
    chk("strobe_latency", n, FRAME_LAT);
    chk("adclk_rises", rises, ADC_BITS);
    chk("adclk_low_when_idle", ck_bad, 0);
    model_expect(int'(raw), code, mv, k1, ledv);
    chk("sample", sample, code);
    chk("volt", volt, mv);
    chk("K_1", K_1, k1);
    chk("led", led, ledv);
    @(negedge clk);
    chk("strobe_width", sample_valid, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_cs_n"}, cs_n, 1);
    chk({tag, "_adclk"}, adclk, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_volt"}, volt, 0);
    chk({tag, "_K_1"}, K_1, 0);
    chk({tag, "_led"}, led, 0);
  endtask

  initial begin
    int  rises;
    bit  got;
    logic pck;
    rst = 1'b1;
    adc_word = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    model_reset();

    do_frame(8'hA5);
`ifndef ADC_AVG_EN
    chk("A5_sample", sample, 8'hA5);
    chk("A5_volt", volt, 16'h084E);
`endif
    do_frame(8'hC8);
`ifndef ADC_AVG_EN
    chk("C8_K_1_set", K_1, 1);
`endif
    do_frame(8'h96);
`ifndef ADC_AVG_EN
    chk("96_K_1_hold", K_1, 1);
`endif
    do_frame(8'h64);
`ifndef ADC_AVG_EN
    chk("64_K_1_clear", K_1, 0);
`endif
    do_frame(8'hFF);
`ifndef ADC_AVG_EN
    chk("FF_led", led, 5'b11111);
`endif
    do_frame(8'h20);
`ifndef ADC_AVG_EN
    chk("20_led", led, 5'b00001);
`endif
    do_frame(8'h00);
`ifndef ADC_AVG_EN
    chk("00_led", led, 5'b00000);
`endif
    do_frame(8'hE0);
    do_frame(8'hF0);

    // Reset in the middle of a frame, after the fourth adclk rise.
    adc_word = 8'h5A;
    got = 0;
    for (int n = 0; n < 2*SAMPLE_PERIOD && !got; n++) begin
      @(negedge clk);
      if (!cs_n) got = 1;
    end
    chk("midrst_cs_fall_seen", got, 1);
    rises = 0; pck = adclk;
    for (int n = 0; n < FRAME_LAT && rises < 4; n++) begin
      @(negedge clk);
      if (adclk && !pck) rises++;
      pck = adclk;
    end
    chk("midrst_rises_before", rises, 4);
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();

    do_frame(8'hA5);
`ifndef ADC_AVG_EN
    chk("post_rst_sample", sample, 8'hA5);
`endif
    repeat (8) do_frame(ADC_BITS'($urandom_range(0, 255)));

`ifdef ADC_AVG_EN
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_frame(8'h40); chk("avg_1", sample, 8'h10);
    do_frame(8'h80); chk("avg_2", sample, 8'h30);
    do_frame(8'hC0); chk("avg_3", sample, 8'h60);
    do_frame(8'h00); chk("avg_4", sample, 8'h60);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
